pong_vga_renderer: RTL and testbench

Display-side consumer of the Pong game core's position words. Takes the player paddle, computer paddle and ball positions (24-bit each) and scans a 640x480@60 Hz VGA raster from the 100 MHz board clock, producing HSync/VSync and 12-bit RGB. Positions are latched once per frame so objects never tear mid-frame. Sits between the game core and the board's VGA connector.

---
 rtl/pong_vga_renderer.sv | 196 +++++++++++++++++++
 tb/tb_pong_vga_renderer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer: scans a VGA raster (640x480@60 Hz by default) from the
// board clock and draws the two Pong paddles, the ball and a dashed centre net.
// Object positions are latched into shadow registers once per frame so that
// nothing tears mid-frame.
//
// Ports:
//   CLK_100MHz          board clock, all logic on rising edge
//   Reset               asynchronous active-low reset
//   PPosition/CPosition paddle top-left, [23:12]=X, [11:0]=Y
//   BPosition           ball top-left, same packing
//   HSync/VSync         active-low sync, registered on the pixel enable
//   Red/Green/Blue      4-bit colour channels, registered with the syncs
//   FrameTick           one-clock pulse on the clock that latches positions
//
// The raster geometry parameters default to standard 640x480 timing.
module pong_vga_renderer #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned PADDLE_W  = 8,
    parameter int unsigned PADDLE_H  = 64,
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic        CLK_100MHz,
    input  logic        Reset,
    input  logic [23:0] PPosition,
    input  logic [23:0] CPosition,
    input  logic [23:0] BPosition,
    output logic        HSync,
    output logic        VSync,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic        FrameTick
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_S = H_ACTIVE + H_FRONT;
    localparam int unsigned H_SYNC_E = H_SYNC_S + H_SYNC;
    localparam int unsigned V_SYNC_S = V_ACTIVE + V_FRONT;
    localparam int unsigned V_SYNC_E = V_SYNC_S + V_SYNC;
    localparam int unsigned H_W      = $clog2(H_TOTAL);
    localparam int unsigned V_W      = $clog2(V_TOTAL);
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SUM_W    = 13;
    localparam int unsigned NET_L    = H_ACTIVE / 2 - 2;
    localparam int unsigned NET_R    = H_ACTIVE / 2 + 1;

    localparam logic [11:0] COL_BALL   = 12'hFF0;
    localparam logic [11:0] COL_PADDLE = 12'hFFF;
    localparam logic [11:0] COL_NET    = 12'h888;
    localparam logic [11:0] COL_BG     = 12'h000;

    logic [DIV_W-1:0] div_q,        div_d;
    logic [H_W-1:0]   hcnt_q,       hcnt_d;
    logic [V_W-1:0]   vcnt_q,       vcnt_d;
    logic [23:0]      p_shadow_q,   p_shadow_d;
    logic [23:0]      c_shadow_q,   c_shadow_d;
    logic [23:0]      b_shadow_q,   b_shadow_d;
    logic             hsync_q,      hsync_d;
    logic             vsync_q,      vsync_d;
    logic [11:0]      rgb_q,        rgb_d;
    logic             frame_tick_q, frame_tick_d;

    logic pix_en_c;
    logic h_last_c;
    logic v_last_c;
    logic visible_c;
    logic ball_c;
    logic pad_c;
    logic net_c;

    // Rectangle hit test in 13-bit arithmetic so X+W never wraps; objects
    // anchored outside the active area are never drawn.
    function automatic logic obj_hit(
        input logic [23:0]      pos,
        input logic [H_W-1:0]   h,
        input logic [V_W-1:0]   v,
        input logic [SUM_W-1:0] w,
        input logic [SUM_W-1:0] ht
    );
        logic [SUM_W-1:0] x;
        logic [SUM_W-1:0] y;
        logic [SUM_W-1:0] hx;
        logic [SUM_W-1:0] vy;
        x  = SUM_W'(pos[23:12]);
        y  = SUM_W'(pos[11:0]);
        hx = SUM_W'(h);
        vy = SUM_W'(v);
        return (x < SUM_W'(H_ACTIVE)) && (y < SUM_W'(V_ACTIVE)) &&
               (hx >= x) && (hx < x + w) &&
               (vy >= y) && (vy < y + ht);
    endfunction

    // Raster decode from the current counters
    assign pix_en_c  = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_last_c  = (hcnt_q == H_W'(H_TOTAL - 1));
    assign v_last_c  = (vcnt_q == V_W'(V_TOTAL - 1));
    assign visible_c = (hcnt_q < H_W'(H_ACTIVE)) && (vcnt_q < V_W'(V_ACTIVE));
    assign ball_c    = obj_hit(b_shadow_q, hcnt_q, vcnt_q,
                               SUM_W'(BALL_SIZE), SUM_W'(BALL_SIZE));
    assign pad_c     = obj_hit(p_shadow_q, hcnt_q, vcnt_q,
                               SUM_W'(PADDLE_W), SUM_W'(PADDLE_H)) ||
                       obj_hit(c_shadow_q, hcnt_q, vcnt_q,
                               SUM_W'(PADDLE_W), SUM_W'(PADDLE_H));
    // Dashed net: 4 columns at screen centre, 16-line dashes
    assign net_c     = (hcnt_q >= H_W'(NET_L)) && (hcnt_q <= H_W'(NET_R)) &&
                       !vcnt_q[4];

    // Next-state: divider, raster counters, frame latch, registered outputs
    always_comb begin
        div_d        = pix_en_c ? '0 : div_q + DIV_W'(1);
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        p_shadow_d   = p_shadow_q;
        c_shadow_d   = c_shadow_q;
        b_shadow_d   = b_shadow_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        rgb_d        = rgb_q;
        frame_tick_d = 1'b0;

        if (pix_en_c) begin
            hcnt_d = h_last_c ? '0 : hcnt_q + H_W'(1);
            if (h_last_c) begin
                vcnt_d = v_last_c ? '0 : vcnt_q + V_W'(1);
            end

            hsync_d = !((hcnt_q >= H_W'(H_SYNC_S)) && (hcnt_q < H_W'(H_SYNC_E)));
            vsync_d = !((vcnt_q >= V_W'(V_SYNC_S)) && (vcnt_q < V_W'(V_SYNC_E)));

            if (!visible_c) begin
                rgb_d = COL_BG;
            end else if (ball_c) begin
                rgb_d = COL_BALL;
            end else if (pad_c) begin
                rgb_d = COL_PADDLE;
            end else if (net_c) begin
                rgb_d = COL_NET;
            end else begin
                rgb_d = COL_BG;
            end

            // Latch on the last pixel of the last visible line, so the whole
            // next frame is drawn from one consistent set of positions.
            if (h_last_c && (vcnt_q == V_W'(V_ACTIVE - 1))) begin
                p_shadow_d   = PPosition;
                c_shadow_d   = CPosition;
                b_shadow_d   = BPosition;
                frame_tick_d = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK_100MHz or negedge Reset) begin
        if (!Reset) begin
            div_q        <= '0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            p_shadow_q   <= '0;
            c_shadow_q   <= '0;
            b_shadow_q   <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            rgb_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            p_shadow_q   <= p_shadow_d;
            c_shadow_q   <= c_shadow_d;
            b_shadow_q   <= b_shadow_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign HSync     = hsync_q;
    assign VSync     = vsync_q;
    assign Red       = rgb_q[11:8];
    assign Green     = rgb_q[7:4];
    assign Blue      = rgb_q[3:0];
    assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// Testbench for pong_vga_renderer on a reduced raster (80x42 total, 64x36
// visible, CLK_DIV=4). Expected pixel/sync/tick values are hand-computed
// constants queued against the clock count at which the DUT presents them;
// a monitor process pops and compares.
module tb_pong_vga_renderer;

    localparam int HT    = 80;
    localparam int VT    = 42;
    localparam int FRAME = HT * VT;
    localparam int DIV   = 4;

    typedef struct {
        int          n;
        int          kind;   // 0 rgb, 1 hsync, 2 vsync, 3 frametick
        logic [11:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] ppos, cpos, bpos;
    logic        hsync, vsync, ftick;
    logic [3:0]  red, green, blue;

    int   cyc;
    int   n_tests = 0;
    int   n_fail  = 0;
    chk_t q[$];
    chk_t e;

    always #5 clk = ~clk;

    pong_vga_renderer #(
        .CLK_DIV(DIV), .PADDLE_W(8), .PADDLE_H(16), .BALL_SIZE(8),
        .H_ACTIVE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_ACTIVE(36), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut (
        .CLK_100MHz(clk),
        .Reset     (rst_n),
        .PPosition (ppos),
        .CPosition (cpos),
        .BPosition (bpos),
        .HSync     (hsync),
        .VSync     (vsync),
        .Red       (red),
        .Green     (green),
        .Blue      (blue),
        .FrameTick (ftick)
    );

    // Rising edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic void check(string name, logic [11:0] act, logic [11:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push(int n, int kind, logic [11:0] exp, string name);
        chk_t c;
        int   i;
        c.n = n; c.kind = kind; c.exp = exp; c.name = name;
        i = q.size();
        while (i > 0 && q[i-1].n > n) i--;
        q.insert(i, c);
    endfunction

    // Output for pixel p is presented from edge DIV*(p+1)
    function automatic int pix_n(int f, int x, int y);
        return DIV * (f * FRAME + y * HT + x + 1);
    endfunction

    function automatic void pix(int f, int x, int y, logic [11:0] rgb);
        push(pix_n(f, x, y), 0, rgb, $sformatf("f%0d(%0d,%0d) rgb", f, x, y));
    endfunction

    function automatic void hs(int f, int x, int y, logic v);
        push(pix_n(f, x, y), 1, 12'(v), $sformatf("f%0d(%0d,%0d) hsync", f, x, y));
    endfunction

    function automatic void vs(int f, int x, int y, logic v);
        push(pix_n(f, x, y), 2, 12'(v), $sformatf("f%0d(%0d,%0d) vsync", f, x, y));
    endfunction

    function automatic void tick(int n, logic v);
        push(n, 3, 12'(v), $sformatf("frametick@%0d", n));
    endfunction

    // Monitor: compare every queued expectation at its clock count
    always @(negedge clk) begin
        if (rst_n) begin
            while (q.size() > 0 && q[0].n <= cyc) begin
                e = q.pop_front();
                if (e.n < cyc) begin
                    check({e.name, " missed"}, 12'(cyc), 12'(e.n));
                end else begin
                    case (e.kind)
                        0:       check(e.name, {red, green, blue}, e.exp);
                        1:       check(e.name, 12'(hsync), e.exp);
                        2:       check(e.name, 12'(vsync), e.exp);
                        default: check(e.name, 12'(ftick), e.exp);
                    endcase
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int k = 0;
        while (q.size() > 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q.size() > 0) begin
            check("drain timeout", 12'(q.size()), 12'd0);
            q.delete();
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, " hsync"}, 12'(hsync), 12'd1);
        check({tag, " vsync"}, 12'(vsync), 12'd1);
        check({tag, " rgb"}, {red, green, blue}, 12'h000);
        check({tag, " frametick"}, 12'(ftick), 12'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        ppos  = {12'd4, 12'd10};
        bpos  = {12'd8, 12'd14};
        cpos  = {12'd60, 12'd30};
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");

        // Frame 0: shadows still zero, all objects at the top-left corner
        pix(0, 0, 0, 12'hFF0);  pix(0, 7, 7, 12'hFF0);  pix(0, 0, 8, 12'hFFF);
        pix(0, 7, 15, 12'hFFF); pix(0, 8, 0, 12'h000);  pix(0, 0, 16, 12'h000);
        pix(0, 30, 0, 12'h888); pix(0, 33, 15, 12'h888); pix(0, 29, 0, 12'h000);
        pix(0, 34, 0, 12'h000); pix(0, 30, 16, 12'h000); pix(0, 31, 32, 12'h888);
        pix(0, 64, 0, 12'h000); pix(0, 0, 36, 12'h000);
        hs(0, 67, 0, 1'b1); hs(0, 68, 0, 1'b0); hs(0, 75, 0, 1'b0); hs(0, 76, 0, 1'b1);
        vs(0, 0, 37, 1'b1); vs(0, 0, 38, 1'b0); vs(0, 79, 39, 1'b0); vs(0, 0, 40, 1'b1);
        tick(11519, 1'b0); tick(11520, 1'b1); tick(11521, 1'b0);
        tick(24959, 1'b0); tick(24960, 1'b1); tick(24961, 1'b0);

        // Frame 1: positions latched at end of frame 0
        pix(1, 0, 0, 12'h000);   pix(1, 4, 10, 12'hFFF);  pix(1, 11, 25, 12'hFFF);
        pix(1, 12, 10, 12'h000); pix(1, 3, 10, 12'h000);  pix(1, 4, 26, 12'h000);
        pix(1, 8, 14, 12'hFF0);  pix(1, 15, 21, 12'hFF0); pix(1, 16, 14, 12'h000);
        pix(1, 11, 20, 12'hFF0); pix(1, 10, 22, 12'hFFF); pix(1, 8, 20, 12'hFF0);
        pix(1, 60, 30, 12'hFFF); pix(1, 63, 35, 12'hFFF); pix(1, 59, 30, 12'h000);
        pix(1, 64, 30, 12'h000); pix(1, 31, 0, 12'h888);  pix(1, 40, 24, 12'h000);
        hs(1, 67, 5, 1'b1); hs(1, 68, 5, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // Mid-frame 1 (line 18): move ball, push computer paddle off-screen
        k = 0;
        while (cyc < DIV * (FRAME + 18 * HT) && k < 30000) begin
            @(negedge clk);
            k++;
        end
        bpos = {12'd40, 12'd24};
        cpos = {12'd700, 12'd10};

        // Frame 2: new positions visible
        pix(2, 40, 24, 12'hFF0); pix(2, 47, 31, 12'hFF0); pix(2, 48, 24, 12'h000);
        pix(2, 40, 32, 12'h000); pix(2, 8, 14, 12'hFFF);  pix(2, 15, 21, 12'h000);
        pix(2, 60, 30, 12'h000); pix(2, 63, 35, 12'h000); pix(2, 4, 10, 12'hFFF);
        hs(2, 70, 38, 1'b0); vs(2, 70, 38, 1'b0); pix(2, 70, 38, 12'h000);
        wait_drain(30000);

        // Reset while both syncs are low
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (3) @(negedge clk);

        // After release: raster restarts, shadows read zero again
        pix(0, 0, 0, 12'hFF0);  pix(0, 7, 7, 12'hFF0);  pix(0, 7, 15, 12'hFFF);
        pix(0, 8, 0, 12'h000);  pix(0, 8, 14, 12'h000); pix(0, 30, 0, 12'h888);
        pix(0, 40, 24, 12'h000);
        hs(0, 68, 0, 1'b0); vs(0, 0, 38, 1'b0);
        rst_n = 1'b1;
        wait_drain(20000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
